// File: rtl/fifo_pkg.sv
// Shared constants and parameter helpers for the single-clock FIFO family.
// Imported by sync_fifo_fwft to derive depth/pointer widths and vet thresholds.
package fifo_pkg;

    localparam bit FIFO_STD  = 1'b0;
    localparam bit FIFO_FWFT = 1'b1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int fifo_ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit afull_level_ok(input int level, input int addr_width);
        return (level >= 1) && (level <= fifo_depth(addr_width));
    endfunction

    function automatic bit aempty_level_ok(input int level, input int addr_width);
        return (level >= 0) && (level <= fifo_depth(addr_width) - 1);
    endfunction

endpackage

// File: rtl/fifomem.sv
// Dual-port FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module fifomem #(
    parameter int datawidth  = 8,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  wclken,
    input  logic [addr_width-1:0] waddr,
    input  logic [datawidth-1:0]  wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [datawidth-1:0]  rdata
);

    localparam int DEPTH = 1 << addr_width;

    logic [datawidth-1:0] mem [DEPTH];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (wclken) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable standard or first-word-fall-through read,
// occupancy count, programmable almost flags and sticky overflow/underflow.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int datawidth    = 8,
    parameter int addr_width   = 3,
    parameter bit fwft         = FIFO_STD,
    parameter int afull_level  = 6,
    parameter int aempty_level = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [datawidth-1:0]  wdata,
    input  logic                  winc,
    input  logic                  rinc,
    output logic [datawidth-1:0]  rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  walmost_full,
    output logic                  ralmost_empty,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(addr_width);
    localparam int PW    = fifo_ptr_width(addr_width);

    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(afull_level);
    localparam logic [PW-1:0] AEMPTY_C = PW'(aempty_level);

    if (!afull_level_ok(afull_level, addr_width)) begin : g_bad_afull
        $error("sync_fifo_fwft: afull_level out of range 1..DEPTH");
    end
    if (!aempty_level_ok(aempty_level, addr_width)) begin : g_bad_aempty
        $error("sync_fifo_fwft: aempty_level out of range 0..DEPTH-1");
    end

    logic [PW-1:0]        wptr, rptr;
    logic [PW-1:0]        wptr_next, rptr_next;
    logic [PW-1:0]        mem_count;
    logic [PW-1:0]        count_next;
    logic                 ov, ov_next;
    logic                 wr_en, rd_en, mem_rd;
    logic                 mem_empty;
    logic [datawidth-1:0] mem_rdata;

    fifomem #(
        .datawidth  (datawidth),
        .addr_width (addr_width)
    ) u_mem (
        .clk    (clk),
        .wclken (wr_en),
        .waddr  (wptr[addr_width-1:0]),
        .wdata  (wdata),
        .raddr  (rptr[addr_width-1:0]),
        .rdata  (mem_rdata)
    );

    // Accept decisions use the registered flags only, so a read in the same
    // cycle never frees room for a write on a full FIFO.
    assign wr_en     = winc & ~wfull;
    assign rd_en     = rinc & ~rempty;
    assign mem_count = wptr - rptr;
    assign mem_empty = (mem_count == '0);

    // In FWFT mode the memory is read whenever the output register is free or
    // being popped; the prefetch sees only words already in memory.
    always_comb begin
        mem_rd  = 1'b0;
        ov_next = 1'b0;
        if (fwft == FIFO_FWFT) begin
            mem_rd  = (~ov | rd_en) & ~mem_empty;
            ov_next = mem_rd ? 1'b1 : (rd_en ? 1'b0 : ov);
        end else begin
            mem_rd  = rd_en;
            ov_next = 1'b0;
        end
    end

    always_comb begin
        wptr_next  = wptr + {{addr_width{1'b0}}, wr_en};
        rptr_next  = rptr + {{addr_width{1'b0}}, mem_rd};
        count_next = (wptr_next - rptr_next) + {{addr_width{1'b0}}, ov_next};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            ov            <= 1'b0;
            rdata         <= '0;
            count         <= '0;
            rempty        <= 1'b1;
            wfull         <= 1'b0;
            walmost_full  <= 1'b0;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            wptr          <= wptr_next;
            rptr          <= rptr_next;
            ov            <= ov_next;
            if (mem_rd) begin
                rdata <= mem_rdata;
            end
            count         <= count_next;
            rempty        <= (fwft == FIFO_FWFT) ? ~ov_next : (count_next == '0);
            wfull         <= (count_next == DEPTH_C);
            walmost_full  <= (count_next >= AFULL_C);
            ralmost_empty <= (count_next <= AEMPTY_C);
            overflow      <= overflow | (winc & wfull);
            underflow     <= underflow | (rinc & rempty);
        end
    end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft: one standard-mode and one FWFT-mode
// instance sharing clock, reset and write data, checked with immediate asserts.
module tb_sync_fifo_fwft;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wdata;

    logic       winc_s, rinc_s;
    logic [7:0] rdata_s;
    logic       wfull_s, rempty_s, walmost_full_s, ralmost_empty_s;
    logic [3:0] count_s;
    logic       overflow_s, underflow_s;

    logic       winc_f, rinc_f;
    logic [7:0] rdata_f;
    logic       wfull_f, rempty_f, walmost_full_f, ralmost_empty_f;
    logic [3:0] count_f;
    logic       overflow_f, underflow_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_fwft #(
        .datawidth(8), .addr_width(3), .fwft(1'b0), .afull_level(6), .aempty_level(1)
    ) u_std (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc_s), .rinc(rinc_s),
        .rdata(rdata_s), .wfull(wfull_s), .rempty(rempty_s),
        .walmost_full(walmost_full_s), .ralmost_empty(ralmost_empty_s),
        .count(count_s), .overflow(overflow_s), .underflow(underflow_s)
    );

    sync_fifo_fwft #(
        .datawidth(8), .addr_width(3), .fwft(1'b1), .afull_level(6), .aempty_level(1)
    ) u_fwft (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc_f), .rinc(rinc_f),
        .rdata(rdata_f), .wfull(wfull_f), .rempty(rempty_f),
        .walmost_full(walmost_full_f), .ralmost_empty(ralmost_empty_f),
        .count(count_f), .overflow(overflow_f), .underflow(underflow_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_count_s", 32'(count_s), 0);
        check("rst_rempty_s", 32'(rempty_s), 1);
        check("rst_wfull_s", 32'(wfull_s), 0);
        check("rst_aempty_s", 32'(ralmost_empty_s), 1);
        check("rst_afull_s", 32'(walmost_full_s), 0);
        check("rst_ovf_s", 32'(overflow_s), 0);
        check("rst_udf_s", 32'(underflow_s), 0);
        check("rst_rdata_s", 32'(rdata_s), 0);
        check("rst_count_f", 32'(count_f), 0);
        check("rst_rempty_f", 32'(rempty_f), 1);
        check("rst_ovf_f", 32'(overflow_f), 0);
        check("rst_rdata_f", 32'(rdata_f), 0);
    endtask

    initial begin
        rst    = 1'b1;
        wdata  = 8'h00;
        winc_s = 1'b0; rinc_s = 1'b0;
        winc_f = 1'b0; rinc_f = 1'b0;
        tick();
        tick();
        check_reset_state();
        rst = 1'b0;
        tick();

        // Standard mode: fill, overflow, drain, underflow.
        for (int i = 1; i <= 8; i++) begin
            wdata = 8'(i); winc_s = 1'b1;
            tick();
            check("fill_count", 32'(count_s), 32'(i));
            check("fill_afull", 32'(walmost_full_s), (i >= 6) ? 1 : 0);
            check("fill_wfull", 32'(wfull_s), (i == 8) ? 1 : 0);
            check("fill_aempty", 32'(ralmost_empty_s), (i <= 1) ? 1 : 0);
        end
        wdata = 8'hEE;
        tick();
        winc_s = 1'b0;
        check("ovf_set", 32'(overflow_s), 1);
        check("ovf_count", 32'(count_s), 8);

        for (int i = 1; i <= 8; i++) begin
            rinc_s = 1'b1;
            tick();
            check("drain_rdata", 32'(rdata_s), 32'(i));
            check("drain_count", 32'(count_s), 32'(8 - i));
            check("drain_rempty", 32'(rempty_s), (i == 8) ? 1 : 0);
        end
        tick();
        rinc_s = 1'b0;
        check("udf_set", 32'(underflow_s), 1);
        check("udf_rdata_hold", 32'(rdata_s), 8'h08);
        check("udf_count", 32'(count_s), 0);
        check("ovf_sticky", 32'(overflow_s), 1);

        // FWFT: single word falls through two edges after the write.
        wdata = 8'hA5; winc_f = 1'b1;
        tick();
        winc_f = 1'b0;
        check("fwft_n_rempty", 32'(rempty_f), 1);
        check("fwft_n_count", 32'(count_f), 1);
        tick();
        check("fwft_n1_rempty", 32'(rempty_f), 0);
        check("fwft_n1_rdata", 32'(rdata_f), 8'hA5);
        rinc_f = 1'b1;
        tick();
        rinc_f = 1'b0;
        check("fwft_pop_rempty", 32'(rempty_f), 1);
        check("fwft_pop_count", 32'(count_f), 0);
        check("fwft_no_udf", 32'(underflow_f), 0);

        // FWFT: hold count at 4 with simultaneous write/pop across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            wdata = 8'(8'h10 + i); winc_f = 1'b1;
            tick();
        end
        winc_f = 1'b0;
        check("sim_pre_count", 32'(count_f), 4);
        check("sim_pre_head", 32'(rdata_f), 8'h10);
        for (int k = 0; k < 20; k++) begin
            wdata = 8'(8'h14 + k); winc_f = 1'b1; rinc_f = 1'b1;
            tick();
            check("sim_count", 32'(count_f), 4);
            check("sim_head", 32'(rdata_f), 32'(8'h11 + k));
            check("sim_rempty", 32'(rempty_f), 0);
        end
        winc_f = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            rinc_f = 1'b1;
            tick();
            check("sim_drain_rdata", 32'(rdata_f), 32'(8'h24 + j));
            check("sim_drain_count", 32'(count_f), 32'(4 - j));
        end
        tick();
        rinc_f = 1'b0;
        check("sim_drain_rempty", 32'(rempty_f), 1);
        check("sim_drain_count0", 32'(count_f), 0);

        // FWFT: full plus pop in one cycle rejects the write.
        for (int i = 0; i < 8; i++) begin
            wdata = 8'(8'h40 + i); winc_f = 1'b1;
            tick();
        end
        check("full_wfull", 32'(wfull_f), 1);
        check("full_count", 32'(count_f), 8);
        wdata = 8'h99; rinc_f = 1'b1;
        tick();
        winc_f = 1'b0;
        check("fullrd_ovf", 32'(overflow_f), 1);
        check("fullrd_count", 32'(count_f), 7);
        check("fullrd_rdata", 32'(rdata_f), 8'h41);
        for (int j = 1; j <= 6; j++) begin
            tick();
            check("fullrd_drain", 32'(rdata_f), 32'(8'h41 + j));
        end
        tick();
        rinc_f = 1'b0;
        check("fullrd_empty", 32'(rempty_f), 1);
        check("fullrd_count0", 32'(count_f), 0);

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 5; i++) begin
            wdata = 8'(8'h50 + i); winc_s = 1'b1;
            tick();
        end
        winc_s = 1'b0;
        check("mid_pre_count", 32'(count_s), 5);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state();
        tick();
        rst = 1'b0;
        wdata = 8'h3C; winc_s = 1'b1; winc_f = 1'b1;
        tick();
        winc_s = 1'b0; winc_f = 1'b0;
        rinc_s = 1'b1;
        tick();
        rinc_s = 1'b0;
        check("post_rst_rdata_s", 32'(rdata_s), 8'h3C);
        check("post_rst_rdata_f", 32'(rdata_f), 8'h3C);
        check("post_rst_rempty_f", 32'(rempty_f), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Single-clock, parametrised FIFO: the next generation of the team's FIFO family for blocks that share one clock domain. Adds a selectable first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. Sits between same-clock producer and consumer pipelines where the gray-pointer synchronisation of the dual-clock FIFO is unnecessary.

## Interface
- datawidth, 8, data word width
- addr_width, 3, memory address width; DEPTH = 2**addr_width words
- fwft, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through
- afull_level, 6, walmost_full asserts when count >= afull_level (1..DEPTH)
- aempty_level, 1, ralmost_empty asserts when count <= aempty_level (0..DEPTH-1)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wdata  in  datawidth  write data
- winc  in  1  write request
- rinc  in  1  read request (standard) / pop head word (fwft)
- rdata  out  datawidth  read data
- wfull  out  1  count == DEPTH
- rempty  out  1  no word readable
- walmost_full  out  1  threshold flag
- ralmost_empty  out  1  threshold flag
- count  out  addr_width+1  words held (memory + fwft output register)
- overflow  out  1  sticky: winc while wfull
- underflow  out  1  sticky: rinc while rempty

## Operation
- Pointers wptr/rptr: addr_width+1-bit binary, wrap mod 2**(addr_width+1); low addr_width bits address memory.
- Write accepted iff winc & !wfull; stores wdata at wptr, wptr+1. A same-cycle read does not unblock a write on a full FIFO.
- Read accepted iff rinc & !rempty.
- Standard mode: accepted read loads mem[rptr] into rdata register, rptr+1; rdata holds otherwise. rempty = (count == 0).
- FWFT mode: output register holds head word with valid bit ov. When !ov or (ov & accepted read) and memory non-empty, prefetch mem[rptr] into rdata, rptr+1. rempty = !ov. rdata is valid whenever rempty is low.
- count = (wptr - rptr) + (fwft ? ov : 0). Accepted write and read in same cycle: count unchanged.
- Capacity is DEPTH in both modes; wfull = (count == DEPTH).
- Rejected winc sets overflow; rejected rinc sets underflow; both cleared only by rst. Rejected requests change no other state.
- Reset (any time, including mid-transfer): pointers 0, ov 0, rdata 0, count 0, rempty 1, wfull 0, ralmost_empty 1, walmost_full 0, overflow 0, underflow 0. Memory contents not reset.

## Timing
- All outputs registered, computed from next-state values; no combinational path from winc/rinc to any output.
- Write at edge N: count/wfull/almost flags update after edge N.
- Standard: rempty deasserts after edge N; read accepted at edge M gives rdata after edge M (1-cycle latency).
- FWFT: write to empty FIFO at edge N -> prefetch at N+1 -> rempty low, rdata valid after edge N+1 (2-cycle fall-through). Back-to-back pops sustain 1 word/cycle while memory non-empty.
- Pointer wrap: no bubble or flag glitch at 2**(addr_width+1) boundary.

## Structure
- Package fifo_pkg: DEPTH derivation, pointer-width constant, mode constants FIFO_STD / FIFO_FWFT, threshold range checks.
- One sub-module: the existing single-port-write/async-read fifomem memory, clocked by clk for writes; this block adds the read register, pointer, flag and count logic.

## Test plan
- Reset then fill: fwft=0, 8 writes 0x01..0x08 -> count 1..8, walmost_full at count 6, wfull at 8; 9th winc -> data ignored, overflow=1.
- Drain standard: after fill, 8 reads -> rdata 0x01..0x08 one cycle after each rinc; rempty at count 0; extra rinc -> underflow=1, rdata holds 0x08.
- FWFT fall-through: fwft=1, single write 0xA5 at edge N -> rempty=0, rdata=0xA5 after N+1; rinc -> rempty=1, count=0.
- Simultaneous: count=4, winc&rinc for 20 cycles -> count stays 4, pointers wrap past 15, data order preserved.
- Full + read same cycle: count=8, winc&rinc -> write rejected, overflow=1, count=7.
- Mid-operation reset: count=5, assert rst asynchronously between edges -> all outputs to reset values immediately; next write 0x3C reads back as 0x3C.
